// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid bit, synchronous flush and a multi-cycle scratch loop.
// Define PIPE_BUBBLE_CNT_EN to build a saturating counter of inserted bubbles.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 72,
  parameter int unsigned SCR_W   = 64,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned STAGE   = 3,
  parameter int unsigned BCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SCR_W-1:0]   scr_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [SCR_W-1:0]   scr_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [BCNT_W-1:0]  bubble_cnt
);

  if (STAGE >= STALL_W) begin : gen_chk_stage
    $error("pipe_stage_reg: STAGE must be below STALL_W");
  end
  if (DATA_W == 0 || SCR_W == 0 || CNT_W == 0) begin : gen_chk_width
    $error("pipe_stage_reg: DATA_W, SCR_W and CNT_W must be at least 1");
  end

  logic us, ds;
  logic unused_stall;

  assign us           = stall[STAGE];
  assign unused_stall = ^stall;

  // The last stage has no downstream stall bit.
  if (STAGE + 1 < STALL_W) begin : gen_ds
    assign ds = stall[STAGE+1];
  end else begin : gen_no_ds
    assign ds = 1'b0;
  end

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [SCR_W-1:0]  scr_d, scr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    scr_d   = '0;
    cnt_d   = '0;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (!us) begin
      valid_d = in_valid;
      data_d  = in_data;
    end else if (!ds) begin
      // Bubble: downstream sees a NOP while the multi-cycle unit loops through us.
      valid_d = 1'b0;
      data_d  = '0;
      scr_d   = scr_i;
      cnt_d   = cnt_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign scr_o     = scr_q;
  assign cnt_o     = cnt_q;

`ifdef PIPE_BUBBLE_CNT_EN
  logic              bubble;
  logic [BCNT_W-1:0] bcnt_d, bcnt_q;

  assign bubble = !flush && us && !ds;

  always_comb begin
    bcnt_d = bcnt_q;
    if (bubble && (bcnt_q != '1)) begin
      bcnt_d = bcnt_q + BCNT_W'(1);
    end
  end

  // Only reset clears the count; flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign bubble_cnt = bcnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised bench for pipe_stage_reg against a rule-level reference model.
// Directed cases cover reset, advance, multi-cycle bubble, hold, flush and the optional counter.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W  = 72;
  localparam int unsigned SCR_W   = 64;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned STALL_W = 6;
  localparam int unsigned STAGE   = 3;
  localparam int unsigned BCNT_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic [SCR_W-1:0]   scr_i;
  logic [CNT_W-1:0]   cnt_i;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [SCR_W-1:0]   scr_o;
  logic [CNT_W-1:0]   cnt_o;
  logic [BCNT_W-1:0]  bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W  (DATA_W),
    .SCR_W   (SCR_W),
    .CNT_W   (CNT_W),
    .STALL_W (STALL_W),
    .STAGE   (STAGE),
    .BCNT_W  (BCNT_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .scr_i      (scr_i),
    .cnt_i      (cnt_i),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .scr_o      (scr_o),
    .cnt_o      (cnt_o),
    .bubble_cnt (bubble_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  logic              exp_v;
  logic [DATA_W-1:0] exp_d;
  logic [SCR_W-1:0]  exp_s;
  logic [CNT_W-1:0]  exp_c;
  int                exp_b;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                          input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, DATA_W'(out_valid), DATA_W'(exp_v));
    check_eq({tag, ".data"}, out_data, exp_d);
    check_eq({tag, ".scr"}, DATA_W'(scr_o), DATA_W'(exp_s));
    check_eq({tag, ".cnt"}, DATA_W'(cnt_o), DATA_W'(exp_c));
    check_eq({tag, ".bcnt"}, DATA_W'(bubble_cnt), DATA_W'(exp_b));
  endtask

  task automatic model_clear();
    exp_v = 1'b0;
    exp_d = '0;
    exp_s = '0;
    exp_c = '0;
    exp_b = 0;
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic step(input string tag, input logic [STALL_W-1:0] st, input logic fl,
                      input logic v, input logic [DATA_W-1:0] d,
                      input logic [SCR_W-1:0] s, input logic [CNT_W-1:0] c);
    logic up, down;
    stall    = st;
    flush    = fl;
    in_valid = v;
    in_data  = d;
    scr_i    = s;
    cnt_i    = c;
    @(posedge clk);
    up   = st[STAGE];
    down = (STAGE == STALL_W - 1) ? 1'b0 : st[STAGE+1];
    if (fl) begin
      exp_v = 1'b0; exp_d = '0; exp_s = '0; exp_c = '0;
    end else if (!up) begin
      exp_v = v; exp_d = d; exp_s = '0; exp_c = '0;
    end else if (!down) begin
      exp_v = 1'b0; exp_d = '0; exp_s = s; exp_c = c;
`ifdef PIPE_BUBBLE_CNT_EN
      if (exp_b < (1 << BCNT_W) - 1) exp_b = exp_b + 1;
`endif
    end else begin
      exp_s = '0; exp_c = '0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    check_all("reset_async");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [95:0] r;
    rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; scr_i = '0; cnt_i = '0;
    model_clear();
    #2 rst = 1'b1;
    #6 rst = 1'b0;
    check_all("por");

    // T1: load a value, then reset mid-cycle must clear before the next edge
    step("t1_load", 6'b000000, 1'b0, 1'b1, 72'hAB, 64'h0, 2'd0);
    check_eq("t1_loaded", out_data, 72'hAB);
    do_reset();
    check_eq("t1_data0", out_data, 72'h0);

    // T2: advance
    step("t2", 6'b000000, 1'b0, 1'b1, 72'h123, 64'hDEAD, 2'd3);
    check_eq("t2_data", out_data, 72'h123);
    check_eq("t2_valid", DATA_W'(out_valid), 72'h1);
    check_eq("t2_scr", DATA_W'(scr_o), 72'h0);

    // T3: two bubble cycles carry the multi-cycle scratch
    step("t3a", 6'b001000, 1'b0, 1'b1, 72'h555, 64'h5, 2'd1);
    check_eq("t3a_scr", DATA_W'(scr_o), 72'h5);
    check_eq("t3a_cnt", DATA_W'(cnt_o), 72'h1);
    check_eq("t3a_data", out_data, 72'h0);
    step("t3b", 6'b001000, 1'b0, 1'b1, 72'h555, 64'hA, 2'd2);
    check_eq("t3b_scr", DATA_W'(scr_o), 72'hA);
    check_eq("t3b_cnt", DATA_W'(cnt_o), 72'h2);
    check_eq("t3b_valid", DATA_W'(out_valid), 72'h0);

    // T4: hold keeps payload, clears scratch
    step("t4_load", 6'b000000, 1'b0, 1'b1, 72'h77, 64'h0, 2'd0);
    step("t4_hold", 6'b011000, 1'b0, 1'b0, 72'h88, 64'h3, 2'd3);
    check_eq("t4_data", out_data, 72'h77);
    check_eq("t4_valid", DATA_W'(out_valid), 72'h1);
    check_eq("t4_scr", DATA_W'(scr_o), 72'h0);

    // T5: flush beats advance
    step("t5", 6'b000000, 1'b1, 1'b1, 72'h99, 64'h9, 2'd1);
    check_eq("t5_data", out_data, 72'h0);
    check_eq("t5_valid", DATA_W'(out_valid), 72'h0);

`ifdef PIPE_BUBBLE_CNT_EN
    // T6: saturating bubble counter survives flush
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("t6", 6'b001000, 1'b0, 1'b0, 72'h0, 64'h1, 2'd1);
      check_eq("t6_bcnt", DATA_W'(bubble_cnt), (i < 3) ? DATA_W'(i + 1) : 72'h3);
    end
    step("t6_flush", 6'b001000, 1'b1, 1'b0, 72'h0, 64'h1, 2'd1);
    check_eq("t6_bcnt_flush", DATA_W'(bubble_cnt), 72'h3);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [STALL_W-1:0] st;
      logic [DATA_W-1:0]  d;
      logic [SCR_W-1:0]   s;
      r  = {$urandom, $urandom, $urandom};
      d  = r[DATA_W-1:0];
      s  = {$urandom, $urandom};
      st = STALL_W'($urandom);
      step("rand", st, ($urandom_range(0, 7) == 0), 1'($urandom), d, s,
           CNT_W'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
